// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and default thresholds for fifo_sync_flags
package fifo_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_L     = 8;
  localparam int DEF_AF_TH = 6;
  localparam int DEF_AE_TH = 2;

  // Address width for a power-of-two depth; pointers carry one extra wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// rtl/fifo_sync_flags_if.sv - producer/consumer signal bundle for fifo_sync_flags
interface fifo_sync_flags_if
  import fifo_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int L = DEF_L
);
  localparam int AW = ptr_w(L);

  logic          w_en;
  logic          r_en;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - W x L simple dual-port RAM, synchronous write, asynchronous read
module fifo_ram #(
  parameter int W  = 8,
  parameter int L  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [L];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with level count, threshold and sticky error flags
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered 1-cycle read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int L     = DEF_L,
  parameter int AF_TH = DEF_AF_TH,
  parameter int AE_TH = DEF_AE_TH
) (
  input logic             clk,
  input logic             rst,
  fifo_sync_flags_if.slave bus
);

  localparam int AW = ptr_w(L);
  localparam logic [AW:0] AF_V = AF_TH[AW:0];
  localparam logic [AW:0] AE_V = AE_TH[AW:0];

  logic [AW:0]  wptr, rptr, wptr_n, rptr_n, cnt_n;
  logic         rd_ok, wr_ok;
  logic [W-1:0] rdata;

  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  assign rd_ok  = bus.r_en && !bus.empty;
  assign wr_ok  = bus.w_en && (!bus.full || rd_ok);
  assign wptr_n = wptr + {{AW{1'b0}}, wr_ok};
  assign rptr_n = rptr + {{AW{1'b0}}, rd_ok};
  assign cnt_n  = wptr_n - rptr_n;

  fifo_ram #(.W(W), .L(L), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr             <= '0;
      rptr             <= '0;
      bus.count        <= '0;
      bus.empty        <= 1'b1;
      bus.full         <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      wptr             <= wptr_n;
      rptr             <= rptr_n;
      bus.count        <= cnt_n;
      bus.empty        <= (wptr_n == rptr_n);
      bus.full         <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      bus.almost_empty <= (cnt_n <= AE_V);
      bus.almost_full  <= (cnt_n >= AF_V);
      if (bus.w_en && !wr_ok) bus.overflow  <= 1'b1;
      if (bus.r_en && !rd_ok) bus.underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; forced to zero while empty so stale RAM never leaks out.
  assign bus.data_out = bus.empty ? '0 : rdata;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bus.data_out <= '0;
    else if (rd_ok) bus.data_out <= rdata;
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - directed self-checking bench for fifo_sync_flags (W=8, L=8, AF=6, AE=2)
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.W(8), .L(8)) bus ();

  fifo_sync_flags #(.W(8), .L(8), .AF_TH(6), .AE_TH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // One clock of stimulus; got is the word delivered by this operation in either output mode.
  task automatic do_op(input logic w, input logic r, input logic [7:0] d, output logic [7:0] got);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
`ifdef FIFO_FWFT_EN
    got = bus.data_out;
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    got = bus.data_out;
`endif
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.w_en = 1'b0; bus.r_en = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", bus.empty); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %0b exp 0", bus.full); else passed++;
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else passed++;
    total++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_almost_empty got %0b exp 1", bus.almost_empty); else passed++;
    total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_almost_full got %0b exp 0", bus.almost_full); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", bus.overflow); else passed++;
    total++; if (bus.underflow !== 1'b0) $display("FAIL reset_underflow got %0b exp 0", bus.underflow); else passed++;
    total++; if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got %0h exp 00", bus.data_out); else passed++;
  endtask

  task automatic test_fill();
    logic [7:0] ae_tab   = 8'b0000_0011;
    logic [7:0] af_tab   = 8'b1110_0000;
    logic [7:0] full_tab = 8'b1000_0000;
    logic [7:0] got;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, 1'b0, 8'(8'h11 * (i + 1)), got);
      total++; if (bus.count !== 4'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i + 1); else passed++;
      total++; if (bus.almost_empty !== ae_tab[i]) $display("FAIL fill_almost_empty[%0d] got %0b exp %0b", i, bus.almost_empty, ae_tab[i]); else passed++;
      total++; if (bus.almost_full !== af_tab[i]) $display("FAIL fill_almost_full[%0d] got %0b exp %0b", i, bus.almost_full, af_tab[i]); else passed++;
      total++; if (bus.full !== full_tab[i]) $display("FAIL fill_full[%0d] got %0b exp %0b", i, bus.full, full_tab[i]); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    do_op(1'b1, 1'b0, 8'h99, got);
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", bus.overflow); else passed++;
    total++; if (bus.count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", bus.count); else passed++;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, 8'h00, got);
      total++; if (got !== 8'(8'h11 * (i + 1))) $display("FAIL ovf_drain[%0d] got %0h exp %0h", i, got, 8'(8'h11 * (i + 1))); else passed++;
    end
    total++; if (bus.empty !== 1'b1) $display("FAIL ovf_drain_empty got %0b exp 1", bus.empty); else passed++;
    total++; if (bus.underflow !== 1'b0) $display("FAIL ovf_no_underflow got %0b exp 0", bus.underflow); else passed++;
  endtask

  task automatic test_underflow();
    logic [7:0] got;
    do_op(1'b0, 1'b1, 8'h00, got);
    total++; if (bus.underflow !== 1'b1) $display("FAIL unf_flag got %0b exp 1", bus.underflow); else passed++;
    total++; if (bus.count !== 4'd0) $display("FAIL unf_count got %0d exp 0", bus.count); else passed++;
`ifndef FIFO_FWFT_EN
    total++; if (bus.data_out !== 8'h88) $display("FAIL unf_data_hold got %0h exp 88", bus.data_out); else passed++;
`endif
    // Read+write on empty: only the write lands.
    do_op(1'b1, 1'b1, 8'h5A, got);
    total++; if (bus.count !== 4'd1) $display("FAIL empty_rw_count got %0d exp 1", bus.count); else passed++;
    total++; if (bus.empty !== 1'b0) $display("FAIL empty_rw_empty got %0b exp 0", bus.empty); else passed++;
`ifndef FIFO_FWFT_EN
    total++; if (bus.data_out !== 8'h88) $display("FAIL empty_rw_data got %0h exp 88", bus.data_out); else passed++;
`endif
    do_op(1'b0, 1'b1, 8'h00, got);
    total++; if (got !== 8'h5A) $display("FAIL empty_rw_read got %0h exp 5a", got); else passed++;
    total++; if (bus.count !== 4'd0) $display("FAIL empty_rw_count_after got %0d exp 0", bus.count); else passed++;
  endtask

  task automatic test_full_pass();
    logic [7:0] got;
    logic [7:0] exp_q [8] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5};
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 8'(8'h11 * (i + 1)), got);
    total++; if (bus.full !== 1'b1) $display("FAIL pass_pre_full got %0b exp 1", bus.full); else passed++;
    do_op(1'b1, 1'b1, 8'hA5, got);
    total++; if (got !== 8'h11) $display("FAIL pass_read got %0h exp 11", got); else passed++;
    total++; if (bus.count !== 4'd8) $display("FAIL pass_count got %0d exp 8", bus.count); else passed++;
    total++; if (bus.full !== 1'b1) $display("FAIL pass_full got %0b exp 1", bus.full); else passed++;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, 8'h00, got);
      total++; if (got !== exp_q[i]) $display("FAIL pass_drain[%0d] got %0h exp %0h", i, got, exp_q[i]); else passed++;
    end
    total++; if (bus.count !== 4'd0) $display("FAIL pass_drain_count got %0d exp 0", bus.count); else passed++;
  endtask

  task automatic test_wrap_reset();
    logic [7:0] got;
    for (int i = 0; i < 20; i++) begin
      do_op(1'b1, 1'b0, 8'(8'h30 + i), got);
      do_op(1'b0, 1'b1, 8'h00, got);
      total++; if (got !== 8'(8'h30 + i)) $display("FAIL wrap_read[%0d] got %0h exp %0h", i, got, 8'(8'h30 + i)); else passed++;
    end
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 8'(8'hC0 + i), got);
    total++; if (bus.count !== 4'd3) $display("FAIL wrap_pre_count got %0d exp 3", bus.count); else passed++;
    total++; if (bus.almost_empty !== 1'b0) $display("FAIL wrap_pre_ae got %0b exp 0", bus.almost_empty); else passed++;
    // Reset lands between edges while a write is being requested.
    bus.w_en = 1'b1; bus.data_in = 8'hEE;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.count !== 4'd0) $display("FAIL arst_count got %0d exp 0", bus.count); else passed++;
    total++; if (bus.empty !== 1'b1) $display("FAIL arst_empty got %0b exp 1", bus.empty); else passed++;
    total++; if (bus.almost_empty !== 1'b1) $display("FAIL arst_ae got %0b exp 1", bus.almost_empty); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL arst_overflow got %0b exp 0", bus.overflow); else passed++;
    total++; if (bus.underflow !== 1'b0) $display("FAIL arst_underflow got %0b exp 0", bus.underflow); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; bus.w_en = 1'b0;
    #1;
    total++; if (bus.count !== 4'd0) $display("FAIL arst_held_count got %0d exp 0", bus.count); else passed++;
    total++; if (bus.data_out !== 8'h00) $display("FAIL arst_data_out got %0h exp 00", bus.data_out); else passed++;
  endtask

  initial begin
    bus.w_en = 1'b0; bus.r_en = 1'b0; bus.data_in = 8'h00;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_pass();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
